xdiv_seq: RTL and testbench

XDIV_SEQ -- requirements
Module: xdiv_seq

---
 rtl/xdiv_seq.sv | 102 ++++++++++
 tb/tb_xdiv_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/xdiv_seq.sv
// Sequential GF(2^8) divide-by-x: y = x * x^-n mod P, one inverse-xtime step per cycle.
// Define XDIV_RS_POLY_EN for P=0x14D (Reed-Solomon field); default is P=0x169 (MDS field).
module xdiv_seq #(
    parameter int N_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     x,
    input  logic [N_W-1:0] n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [7:0]     y
);

`ifdef XDIV_RS_POLY_EN
    localparam logic [7:0] P_LO = 8'h4D;
`else
    localparam logic [7:0] P_LO = 8'h69;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_reg;
    logic [7:0]     acc_reg;
    logic [N_W-1:0] cnt_reg;
    logic [7:0]     y_reg;
    logic           busy_reg;
    logic           done_reg;
    logic [7:0]     acc_next;

    // Inverse of xtime: odd values fold in the reduction polynomial before shifting
    // right, and the bit that was the x^8 term reappears as bit 7.
    function automatic logic [7:0] inv_xtime(input logic [7:0] a);
        if (a[0])
            return ((a ^ P_LO) >> 1) | 8'h80;
        else
            return a >> 1;
    endfunction

    assign acc_next = inv_xtime(acc_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= 8'h00;
            cnt_reg   <= '0;
            y_reg     <= 8'h00;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= LOAD;
                        acc_reg   <= x;
                        cnt_reg   <= n;
                        busy_reg  <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                LOAD: begin
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                        y_reg     <= acc_reg;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg - N_W'(1);
                    // y is loaded on entry to DONE so it is valid while done is high
                    if (cnt_reg == N_W'(1)) begin
                        state_reg <= DONE;
                        y_reg     <= acc_next;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign y    = y_reg;

endmodule

// File: tb/tb_xdiv_seq.sv
// Directed self-checking bench for xdiv_seq: latency, field results, busy drop, reset abort, n=1 sweep.
module tb_xdiv_seq;

`ifdef XDIV_RS_POLY_EN
    localparam logic [8:0] POLY    = 9'h14D;
    localparam logic [7:0] EXP_ONE = 8'hA6;
`else
    localparam logic [8:0] POLY    = 9'h169;
    localparam logic [7:0] EXP_ONE = 8'hB4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] x   = 8'h00;
    logic [2:0] n   = 3'd0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] y;

    int total = 0;
    int bad   = 0;

    xdiv_seq #(.N_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .n     (n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        logic [8:0] t;
        t = {a, 1'b0};
        if (a[7]) t = t ^ POLY;
        return t[7:0];
    endfunction

    // Waits for done after an accepted start; cyc counts the accept cycle as cycle 1.
    task automatic wait_done(output logic [7:0] yo, output int cyc, output int overlap);
        cyc = 1;
        overlap = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (busy && done) overlap++;
        end
        yo = y;
    endtask

    task automatic do_op(input logic [7:0] xi, input logic [2:0] ni,
                         output logic [7:0] yo, output int cyc, output int overlap);
        @(negedge clk);
        x = xi; n = ni; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(yo, cyc, overlap);
    endtask

    logic [7:0] yv;
    int         cyc, ov, pulses;

    initial begin
        rst = 1'b1;
        #12;
        check("reset_y", y, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk); rst = 1'b0;

        do_op(8'h69, 3'd1, yv, cyc, ov);
        $display("op x=69 n=1 y=%02h cyc=%0d", yv, cyc);
        check("x69_y", yv, 8'h80);
        check("x69_cyc", cyc, 3);
        check("x69_overlap", ov, 0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("y_hold", y, 8'h80);

        do_op(8'h01, 3'd1, yv, cyc, ov);
        $display("op x=01 n=1 y=%02h cyc=%0d", yv, cyc);
        check("x01_y", yv, EXP_ONE);

        do_op(8'h80, 3'd7, yv, cyc, ov);
        $display("op x=80 n=7 y=%02h cyc=%0d", yv, cyc);
        check("x80_y", yv, 8'h01);
        check("x80_cyc", cyc, 9);

        do_op(8'h5A, 3'd0, yv, cyc, ov);
        $display("op x=5a n=0 y=%02h cyc=%0d", yv, cyc);
        check("x5a_y", yv, 8'h5A);
        check("x5a_cyc", cyc, 2);

        do_op(8'h00, 3'd5, yv, cyc, ov);
        $display("op x=00 n=5 y=%02h cyc=%0d", yv, cyc);
        check("x00_y", yv, 8'h00);

        // Back-to-back: start asserted during the done cycle.
        x = 8'h80; n = 3'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done_low", done, 0);
        wait_done(yv, cyc, ov);
        $display("op b2b x=80 n=1 y=%02h cyc=%0d", yv, cyc);
        check("b2b_y", yv, 8'h40);
        check("b2b_cyc", cyc, 3);

        // Second request while busy must be dropped; inputs change under it.
        @(negedge clk);
        x = 8'h02; n = 3'd3; start = 1'b1;
        @(negedge clk);
        x = 8'hFF; n = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        yv = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin pulses++; yv = y; end
        end
        $display("op busy-drop x=02 n=3 y=%02h pulses=%0d", yv, pulses);
        check("drop_pulses", pulses, 1);
        check("drop_y", yv, 8'h5A);
        check("drop_idle", busy, 0);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        x = 8'h80; n = 3'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_y", y, 8'h00);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        $display("op reset-abort pulses=%0d", pulses);
        check("rst_no_done", pulses, 0);
        do_op(8'h69, 3'd1, yv, cyc, ov);
        $display("op after-reset x=69 n=1 y=%02h cyc=%0d", yv, cyc);
        check("post_rst_y", yv, 8'h80);
        check("post_rst_cyc", cyc, 3);

        // n=1 sweep: applying xtime to the result must return the operand.
        for (int v = 0; v < 256; v++) begin
            do_op(8'(v), 3'd1, yv, cyc, ov);
            $display("op sweep x=%02h n=1 y=%02h", v[7:0], yv);
            check("sweep_inv", xtime(yv), v);
            check("sweep_overlap", ov, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
